// File: rtl/mem_io_ctrl_if.sv
// CPU byte bus, RAM port and UART TX/RX wires grouped for the memory/IO controller.
// No logic; the slave modport is the controller's view, master is the CPU/board view.
// Flow control carried here: io_buffer_full to the CPU, tx_valid/tx_ready to the UART.
interface mem_io_ctrl_if;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic        ram_we;
    logic [7:0]  ram_d;
    logic [7:0]  ram_q;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_pop;

    modport slave (
        input  cpu_a, cpu_dout, cpu_wr, ram_q, tx_ready, rx_valid, rx_data,
        output cpu_din, io_buffer_full, ram_a, ram_we, ram_d, tx_valid, tx_data, rx_pop
    );

    modport master (
        output cpu_a, cpu_dout, cpu_wr, ram_q, tx_ready, rx_valid, rx_data,
        input  cpu_din, io_buffer_full, ram_a, ram_we, ram_d, tx_valid, tx_data, rx_pop
    );
endinterface

// File: rtl/mem_io_ctrl.sv
// Address decoder: RAM steering, UART TX FIFO, RX pop, coherent 32-bit cycle counter, program stop.
// Read data returns exactly one cycle after the access; RAM writes are combinational.
// io_buffer_full warns the CPU MARGIN slots early; a push into a full FIFO is dropped and flagged.
module mem_io_ctrl #(
    parameter int DEPTH  = 16,
    parameter int MARGIN = 2
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          rdy_in,
    mem_io_ctrl_if.slave  bus,
    output logic          halted,
    output logic          done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] WARN_CNT = CW'(DEPTH - MARGIN);

    // Source of the byte returned on cpu_din in the cycle after a read.
    typedef enum logic {SEL_IO = 1'b0, SEL_RAM = 1'b1} sel_e;

    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   snap_q, snap_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          halted_q, halted_d;
    logic          done_q, done_d;
    sel_e          sel_q, sel_d;
    logic [7:0]    io_dat_q, io_dat_d;
    logic [7:0]    fifo_mem [DEPTH];

    // Only [17:0] of the CPU address is decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.cpu_a[31:18];

    logic        io_sel;
    logic [15:0] io_off;
    logic        acc_wr;
    logic        acc_rd;
    logic        halt_set;
    logic        tx_push;
    logic [7:0]  push_dat;
    logic        tx_pop;
    logic        push_ok;

    assign io_sel   = (bus.cpu_a[17:16] == 2'b11);
    assign io_off   = bus.cpu_a[15:0];
    // Once halted, every CPU write (RAM or IO) is dropped.
    assign acc_wr   = rdy_in && bus.cpu_wr && !halted_q;
    assign acc_rd   = rdy_in && !bus.cpu_wr;
    assign halt_set = acc_wr && io_sel && (io_off == 16'h0004);
    // A zero byte to the data port is ignored; the stop write queues a zero terminator.
    assign tx_push  = halt_set ||
                      (acc_wr && io_sel && (io_off == 16'h0000) && (bus.cpu_dout != 8'h00));
    assign push_dat = halt_set ? 8'h00 : bus.cpu_dout;
    assign tx_pop   = (count_q != '0) && bus.tx_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok  = tx_push && ((count_q != FULL_CNT) || tx_pop);

    assign bus.ram_a          = bus.cpu_a[16:0];
    assign bus.ram_d          = bus.cpu_dout;
    assign bus.ram_we         = acc_wr && !io_sel;
    assign bus.rx_pop         = acc_rd && io_sel && (io_off == 16'h0000) && bus.rx_valid;
    assign bus.cpu_din        = (sel_q == SEL_RAM) ? bus.ram_q : io_dat_q;
    assign bus.tx_valid       = (count_q != '0);
    assign bus.tx_data        = fifo_mem[rd_ptr_q];
    assign bus.io_buffer_full = (count_q >= WARN_CNT);
    assign halted             = halted_q;
    assign done               = done_q;

    // Read path and cycle counter: select source, capture IO byte, snapshot on byte-0 read.
    always_comb begin
        cnt_d    = cnt_q;
        snap_d   = snap_q;
        sel_d    = sel_q;
        io_dat_d = io_dat_q;
        if (rdy_in) begin
            cnt_d = cnt_q + 32'd1;
        end
        if (acc_rd) begin
            sel_d    = io_sel ? SEL_IO : SEL_RAM;
            io_dat_d = 8'h00;
            if (io_sel) begin
                case (io_off)
                    16'h0000: io_dat_d = bus.rx_valid ? bus.rx_data : 8'h00;
                    16'h0004: begin
                        io_dat_d = cnt_q[7:0];
                        snap_d   = cnt_q;
                    end
                    16'h0005: io_dat_d = snap_q[15:8];
                    16'h0006: io_dat_d = snap_q[23:16];
                    16'h0007: io_dat_d = snap_q[31:24];
                    default:  io_dat_d = 8'h00;
                endcase
            end
        end
    end

    // TX FIFO bookkeeping, overflow flag, halt and done tracking.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        halted_d = halted_q || halt_set;
        done_d   = halted_q && (count_q == '0);
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (tx_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, tx_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (tx_push && !push_ok) begin
            ovf_d = 1'b1;
        end
    end

    // State registers; the FIFO storage itself needs no reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q    <= '0;
            snap_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            halted_q <= 1'b0;
            done_q   <= 1'b0;
            sel_q    <= SEL_IO;
            io_dat_q <= 8'h00;
        end else begin
            cnt_q    <= cnt_d;
            snap_q   <= snap_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            halted_q <= halted_d;
            done_q   <= done_d;
            sel_q    <= sel_d;
            io_dat_q <= io_dat_d;
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= push_dat;
        end
    end
endmodule

// File: tb/tb_mem_io_ctrl.sv
module tb_mem_io_ctrl;
    localparam int DEPTH  = 16;
    localparam int MARGIN = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b0;
    logic halted;
    logic done;

    mem_io_ctrl_if bus();

    mem_io_ctrl #(.DEPTH(DEPTH), .MARGIN(MARGIN)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rdy_in   (rdy),
        .bus      (bus),
        .halted   (halted),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Board RAM: synchronous read, unwritten bytes read as zero.
    logic [7:0] bram [int];
    always @(posedge clk) begin
        logic [7:0] rd;
        int idx;
        idx = int'(bus.ram_a);
        rd  = bram.exists(idx) ? bram[idx] : 8'h00;
        if (bus.ram_we === 1'b1) bram[idx] = bus.ram_d;
        bus.ram_q <= rd;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state.
    logic [7:0]  q[$];
    logic [7:0]  mmem [int];
    logic [31:0] m_cnt, m_snap, last_a;
    logic [7:0]  din_exp;
    bit          m_halt, m_done, m_ovf, din_ok;

    task automatic model_reset();
        q.delete();
        m_cnt = 0; m_snap = 0; m_halt = 0; m_done = 0; m_ovf = 0;
        din_exp = 8'h00; din_ok = 1;
    endtask

    // One bus cycle: drive after negedge, check, clock, advance the model.
    task automatic step(input bit r, input logic [31:0] a_in, input bit w, input logic [7:0] d,
                        input bit txr, input bit rxv, input logic [7:0] rxd);
        logic [31:0] a;
        logic [15:0] off;
        logic [7:0]  pv;
        bit io, acc_wr, acc_rd, pop, push;
        a = r ? a_in : last_a;   // address held while not ready
        rdy = r; bus.cpu_a = a; bus.cpu_wr = w; bus.cpu_dout = d;
        bus.tx_ready = txr; bus.rx_valid = rxv; bus.rx_data = rxd;
        io     = (a[17:16] == 2'b11);
        off    = a[15:0];
        acc_wr = r && w && !m_halt;
        acc_rd = r && !w;
        #1;
        chk("ram_we", 32'(bus.ram_we), 32'(acc_wr && !io));
        chk("ram_a", 32'(bus.ram_a), 32'(a[16:0]));
        if (acc_wr && !io) chk("ram_d", 32'(bus.ram_d), 32'(d));
        chk("rx_pop", 32'(bus.rx_pop), 32'(acc_rd && io && off == 16'h0 && rxv));
        if (din_ok) chk("cpu_din", 32'(bus.cpu_din), 32'(din_exp));
        chk("tx_valid", 32'(bus.tx_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("tx_data", 32'(bus.tx_data), 32'(q[0]));
        chk("buf_full", 32'(bus.io_buffer_full), 32'(q.size() >= DEPTH - MARGIN));
        chk("halted", 32'(halted), 32'(m_halt));
        chk("done", 32'(done), 32'(m_done));
        chk("ovf", 32'(dut.ovf_q), 32'(m_ovf));
        @(posedge clk);
        pop    = (q.size() != 0) && txr;
        m_done = m_halt && (q.size() == 0);
        push = 0; pv = 8'h00;
        if (acc_wr && io && off == 16'h0 && d != 8'h00) begin push = 1; pv = d; end
        if (acc_wr && io && off == 16'h4) begin push = 1; pv = 8'h00; m_halt = 1; end
        if (pop) void'(q.pop_front());
        if (push) begin
            if (q.size() < DEPTH) q.push_back(pv);
            else m_ovf = 1;
        end
        if (acc_wr && !io) mmem[int'(a[16:0])] = d;
        if (r && w) din_ok = 0;
        if (acc_rd) begin
            din_ok = 1;
            if (!io) din_exp = mmem.exists(int'(a[16:0])) ? mmem[int'(a[16:0])] : 8'h00;
            else begin
                case (off)
                    16'h0:   din_exp = rxv ? rxd : 8'h00;
                    16'h4:   begin din_exp = m_cnt[7:0]; m_snap = m_cnt; end
                    16'h5:   din_exp = m_snap[15:8];
                    16'h6:   din_exp = m_snap[23:16];
                    16'h7:   din_exp = m_snap[31:24];
                    default: din_exp = 8'h00;
                endcase
            end
        end
        if (r) m_cnt = m_cnt + 32'd1;
        last_a = a;
        @(negedge clk);
    endtask

    task automatic idle(input bit txr);
        step(1'b1, 32'h0, 1'b0, 8'h00, txr, 1'b0, 8'h00);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic do_reset();
        rdy = 1'b0; bus.cpu_a = 32'h0; bus.cpu_wr = 1'b0; bus.cpu_dout = 8'h00;
        bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        chk("rst_buf_full", 32'(bus.io_buffer_full), 32'h0);
        chk("rst_cpu_din", 32'(bus.cpu_din), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_ram_we", 32'(bus.ram_we), 32'h0);
        chk("rst_rx_pop", 32'(bus.rx_pop), 32'h0);
        chk("rst_ovf", 32'(dut.ovf_q), 32'h0);
        model_reset();
        last_a = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] offs [8];
        offs = '{16'h0, 16'h0, 16'h1, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8};
        model_reset();
        last_a = 32'h0;
        @(negedge clk);
        do_reset();

        // RAM write then read back with one-cycle latency.
        step(1, 32'h0000_0100, 1, 8'hA5, 0, 0, 8'h00);
        step(1, 32'h0000_0100, 0, 8'h00, 0, 0, 8'h00);
        idle(0);

        // Fill to the warning level with the UART stalled, then drain.
        for (int i = 1; i <= 14; i++) step(1, 32'h0003_0000, 1, 8'(i), 0, 0, 8'h00);
        for (int i = 0; i < 18; i++) idle(1);

        // Zero byte to the data port is ignored.
        step(1, 32'h0003_0000, 1, 8'h00, 0, 0, 8'h00);
        idle(0);

        // Overflow, then push+pop while full.
        for (int i = 0; i < 18; i++) step(1, 32'h0003_0000, 1, 8'(8'h20 + i), 0, 0, 8'h00);
        step(1, 32'h0003_0000, 1, 8'hEE, 1, 0, 8'h00);
        idle(0);
        for (int i = 0; i < 20; i++) idle(1);

        // Counter snapshot coherence across a byte-1 carry, with a stall in between.
        for (int i = 0; i < 300 && m_cnt[7:0] != 8'hFF; i++) idle(0);
        step(1, 32'h0003_0004, 0, 8'h00, 0, 0, 8'h00);
        step(1, 32'h0003_0005, 0, 8'h00, 0, 0, 8'h00);
        step(0, 32'h0, 0, 8'h00, 0, 0, 8'h00);
        step(0, 32'h0, 0, 8'h00, 0, 0, 8'h00);
        step(1, 32'h0003_0006, 0, 8'h00, 0, 0, 8'h00);
        step(1, 32'h0003_0007, 0, 8'h00, 0, 0, 8'h00);
        idle(0);

        // UART receive with and without data.
        step(1, 32'h0003_0000, 0, 8'h00, 0, 1, 8'h41);
        step(1, 32'h0003_0000, 0, 8'h00, 0, 0, 8'h42);
        idle(0);

        // Randomized traffic (stop address excluded).
        for (int n = 0; n < 600; n++) begin
            bit r, w, txr, rxv;
            int kind;
            logic [31:0] a;
            logic [15:0] off;
            logic [7:0] d;
            r    = ($urandom_range(0, 3) != 0);
            w    = ($urandom_range(0, 1) != 0);
            kind = $urandom_range(0, 2);
            a    = {14'($urandom), 18'h0};
            if (kind == 0) a[17:0] = 18'h00100 + 18'($urandom_range(0, 15));
            else if (kind == 1) a[17:0] = 18'h1FFF0 + 18'($urandom_range(0, 15));
            else begin
                off = offs[$urandom_range(0, 7)];
                if (w && off == 16'h4) off = 16'h5;
                a[17:0] = {2'b11, off};
            end
            d   = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            txr = ($urandom_range(0, 3) == 0);
            rxv = ($urandom_range(0, 1) != 0);
            step(r, a, w, d, txr, rxv, 8'($urandom));
        end

        // Reset with bytes queued discards them.
        idle(0);
        for (int i = 0; i < 3; i++) step(1, 32'h0003_0000, 1, 8'(8'h60 + i), 0, 0, 8'h00);
        do_reset();
        idle(0);

        // Program stop: three bytes plus the zero terminator drain, then done.
        step(1, 32'h0000_0100, 1, 8'h5A, 0, 0, 8'h00);
        step(1, 32'h0003_0000, 1, 8'h11, 0, 0, 8'h00);
        step(1, 32'h0003_0000, 1, 8'h22, 0, 0, 8'h00);
        step(1, 32'h0003_0000, 1, 8'h33, 0, 0, 8'h00);
        step(1, 32'h0003_0004, 1, 8'h99, 0, 0, 8'h00);
        idle(0);
        for (int i = 0; i < 7; i++) idle(1);
        step(1, 32'h0003_0000, 1, 8'h55, 1, 0, 8'h00);
        step(1, 32'h0000_0100, 1, 8'h77, 1, 0, 8'h00);
        step(1, 32'h0000_0100, 0, 8'h00, 1, 0, 8'h00);
        idle(1);
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
